// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl
// Sequencer for an in-place, 16-point, radix-2 DIT FFT. Data is assumed
// to be stored in bit-reversed order. The sequencer issues 8 butterfly
// operand pairs per stage for 4 stages. After each stage it waits BF_LAT
// cycles so that the butterfly results are written back before the next
// stage reads them.
//
// Ports
//   clk, rst_n            : clock; asynchronous active-low reset
//   start                 : request one transform; only sampled in IDLE
//   rd_valid              : operand issue strobe
//   rd_addr_a, rd_addr_b  : upper and lower leg operand addresses
//   tw_addr               : twiddle index k of W16^k, valid with rd_valid
//   wr_en                 : result write strobe (rd_valid delayed BF_LAT cycles)
//   wr_addr_a, wr_addr_b  : result addresses (rd_addr_* delayed BF_LAT cycles)
//   stage                 : index of the stage that is issuing
//   busy                  : high while running or draining
//   done                  : one-cycle completion pulse
module fft_stage_ctrl #(
  parameter int unsigned BF_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       rd_valid,
  output logic [3:0] rd_addr_a,
  output logic [3:0] rd_addr_b,
  output logic [2:0] tw_addr,
  output logic       wr_en,
  output logic [3:0] wr_addr_a,
  output logic [3:0] wr_addr_b,
  output logic [1:0] stage,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] DRAIN_LAST = 2'(BF_LAT - 1);

  logic [1:0] state, n_state;
  logic [1:0] s, n_s;
  logic [2:0] j, n_j;
  logic [1:0] cnt, n_cnt;

  // Next-state logic. The outputs are registered from these next values,
  // so each output is valid in the same cycle as the state that it describes.
  always_comb begin
    n_state = state;
    n_s     = s;
    n_j     = j;
    n_cnt   = cnt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          n_state = ST_RUN;
          n_s     = '0;
          n_j     = '0;
        end
      end
      ST_RUN: begin
        if (j == 3'd7) begin
          n_state = ST_DRAIN;
          n_cnt   = '0;
        end else begin
          n_j = j + 3'd1;
        end
      end
      ST_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          if (s == 2'd3) begin
            n_state = ST_DONE;
          end else begin
            n_state = ST_RUN;
            n_s     = s + 2'd1;
            n_j     = '0;
          end
        end else begin
          n_cnt = cnt + 2'd1;
        end
      end
      default: n_state = ST_IDLE;
    endcase
  end

  // Butterfly addressing for stage n_s and index n_j.
  // half = 2^s, pos = j mod half, group = j div half.
  logic [3:0] half, pos, grp, a_nx, b_nx;
  logic [2:0] tw_nx;

  always_comb begin
    half  = 4'd1 << n_s;
    pos   = {1'b0, n_j} & (half - 4'd1);
    grp   = {1'b0, n_j} >> n_s;
    a_nx  = (grp << ({1'b0, n_s} + 3'd1)) | pos;
    b_nx  = a_nx + half;
    tw_nx = 3'(pos << (2'd3 - n_s));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      s         <= '0;
      j         <= '0;
      cnt       <= '0;
      rd_valid  <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
      stage     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state    <= n_state;
      s        <= n_s;
      j        <= n_j;
      cnt      <= n_cnt;
      rd_valid <= (n_state == ST_RUN);
      busy     <= (n_state == ST_RUN) || (n_state == ST_DRAIN);
      done     <= (n_state == ST_DONE);
      if (n_state == ST_RUN) begin
        rd_addr_a <= a_nx;
        rd_addr_b <= b_nx;
        tw_addr   <= tw_nx;
        stage     <= n_s;
      end
    end
  end

  // Write-back delay line. The address taps shift every cycle. rd_addr_*
  // holds its value between issues, so the tail of the line keeps the last
  // written address while wr_en is low.
  logic [BF_LAT-1:0] v_pipe;
  logic [3:0]        a_pipe [BF_LAT];
  logic [3:0]        b_pipe [BF_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_pipe <= '0;
      for (int unsigned i = 0; i < BF_LAT; i++) begin
        a_pipe[i] <= '0;
        b_pipe[i] <= '0;
      end
    end else begin
      v_pipe[0] <= rd_valid;
      a_pipe[0] <= rd_addr_a;
      b_pipe[0] <= rd_addr_b;
      for (int unsigned i = 1; i < BF_LAT; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        a_pipe[i] <= a_pipe[i-1];
        b_pipe[i] <= b_pipe[i-1];
      end
    end
  end

  assign wr_en     = v_pipe[BF_LAT-1];
  assign wr_addr_a = a_pipe[BF_LAT-1];
  assign wr_addr_b = b_pipe[BF_LAT-1];

endmodule

// File: doc/fft_stage_ctrl.md
FFT_STAGE_CTRL -- requirements
Module: fft_stage_ctrl

Interface
REQ-001 Parameter: BF_LAT, default 2, butterfly datapath latency in cycles from operand issue to result write-back; legal range 1..4.
REQ-002 clk  input  1  single system clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request one 16-point transform; sampled only in IDLE.
REQ-005 rd_valid  output  1  operand pair issue strobe to butterfly and data RAM.
REQ-006 rd_addr_a  output  4  upper-leg operand address.
REQ-007 rd_addr_b  output  4  lower-leg operand address.
REQ-008 tw_addr  output  3  twiddle index k (W16^k) to twiddle LUT, valid with rd_valid.
REQ-009 wr_en  output  1  result write strobe to data RAM.
REQ-010 wr_addr_a  output  4  write address for upper-leg result.
REQ-011 wr_addr_b  output  4  write address for lower-leg result.
REQ-012 stage  output  2  current stage index s of the issuing stage.
REQ-013 busy  output  1  high in RUN and DRAIN.
REQ-014 done  output  1  one-cycle completion pulse.

Function
REQ-015 FSM states IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE: start=1 -> RUN with s=0, j=0 next cycle; start=0 -> stay.
REQ-017 RUN: rd_valid=1 every cycle; j increments 0..7; after issuing j=7 -> DRAIN.
REQ-018 DRAIN: rd_valid=0 for exactly BF_LAT cycles; then s<3 -> RUN with s+1, j=0; s=3 -> DONE.
REQ-019 DONE: done=1, busy=0 for one cycle, then IDLE unconditionally.
REQ-020 Addressing for s, j (radix-2 DIT, bit-reversed input order): half=2^s, pos=j mod half, group=j div half, rd_addr_a=group*2*half+pos, rd_addr_b=rd_addr_a+half, tw_addr=pos*2^(3-s); all results exact, no wrap.
REQ-021 Write-back: wr_en, wr_addr_a, wr_addr_b equal rd_valid, rd_addr_a, rd_addr_b delayed by exactly BF_LAT cycles via a shift register.
REQ-022 Last write of stage s coincides with the final DRAIN cycle; first read of stage s+1 occurs the following cycle (no read-after-write hazard).
REQ-023 Total latency start-to-done: 4*(8+BF_LAT)+1 cycles; start sampled cycle 0, done at that cycle.
REQ-024 start while busy or in DONE: ignored, no queuing.
REQ-025 Outputs are registered; rd_* and stage hold their last value when rd_valid=0; wr_addr_* undefined-free (hold last) when wr_en=0.
REQ-026 Back-to-back: start asserted in the cycle after done starts a new transform normally.

Reset
REQ-027 rst_n low: immediately (asynchronously) FSM=IDLE, s=0, j=0, delay line cleared.
REQ-028 Reset values: rd_valid=0, rd_addr_a=0, rd_addr_b=0, tw_addr=0, wr_en=0, wr_addr_a=0, wr_addr_b=0, stage=0, busy=0, done=0.
REQ-029 Reset mid-transform: no wr_en pulse after rst_n deassertion until a new start has been issued and BF_LAT cycles elapsed.
REQ-030 First start accepted on the first rising edge with rst_n high.

Verification
REQ-031 BF_LAT=2, start pulse at cycle 0 -> busy 1 cycles 1..40, done=1 cycle 41 only, exactly 32 rd_valid and 32 wr_en pulses.
REQ-032 Address spot checks: s=0,j=5 -> a=10,b=11,k=0; s=1,j=3 -> a=5,b=7,k=4; s=2,j=6 -> a=10,b=14,k=4; s=3,j=7 -> a=7,b=15,k=7.
REQ-033 Per stage, every address 0..15 appears exactly once across {rd_addr_a, rd_addr_b}; each wr_en matches rd_valid addresses of BF_LAT cycles earlier (BF_LAT=1 and 4 runs).
REQ-034 start held high continuously -> transforms repeat with one IDLE cycle between done and next busy; start pulses during busy have no effect.
REQ-035 rst_n low at cycle 15 of a transform -> all outputs 0 in that cycle asynchronously; no wr_en afterward until restart; restart completes with correct counts.
